// File: rtl/mem_lsu_if.sv
// Data-memory bus seen by the MEM-stage load/store unit: one request channel
// (valid/ready) and one load-response channel (valid only).
interface mem_lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns an EX/MEM access into one bus transaction,
// stalls the pipeline while it is outstanding and returns extended load data.
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    mem_lsu_if.master   bus
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic        r_req_valid;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_rdata;
    logic        r_buserr;

    logic        w_acc;
    logic        w_aligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_tmo;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_acc = MemReadM | MemWriteM;

    always_comb begin
        w_aligned = 1'b0;
        w_be      = 4'b0000;
        w_wdata   = 32'h0;
        case (Funct3M[1:0])
            2'b00: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << ALUResultM[1:0];
                w_wdata   = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_aligned = ~ALUResultM[0];
                w_be      = ALUResultM[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{WriteDataM[15:0]}};
            end
            2'b10: begin
                w_aligned = (ALUResultM[1:0] == 2'b00);
                w_be      = 4'b1111;
                w_wdata   = WriteDataM;
            end
            default: ;
        endcase
        // Loads still carry lane enables but never put data on the bus.
        if (!MemWriteM) w_wdata = 32'h0;
    end

    always_comb begin
        w_byte = 8'h0;
        case (r_off)
            2'd0: w_byte = bus.mem_resp_rdata[7:0];
            2'd1: w_byte = bus.mem_resp_rdata[15:8];
            2'd2: w_byte = bus.mem_resp_rdata[23:16];
            2'd3: w_byte = bus.mem_resp_rdata[31:24];
            default: ;
        endcase
        w_half = r_off[1] ? bus.mem_resp_rdata[31:16] : bus.mem_resp_rdata[15:0];
        case (r_size)
            2'b00:   w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{~r_uns & w_half[15]}}, w_half};
            default: w_ext = bus.mem_resp_rdata;
        endcase
    end

    assign w_tmo = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_valid <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_be        <= 4'b0000;
            r_off       <= 2'b00;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_rdata     <= 32'h0;
            r_buserr    <= 1'b0;
        end else begin
            r_buserr <= 1'b0;
            case (r_state)
                IDLE: if (w_acc && w_aligned) begin
                    r_state     <= REQ;
                    r_cnt       <= '0;
                    r_req_valid <= 1'b1;
                    r_we        <= MemWriteM;
                    r_addr      <= {ALUResultM[31:2], 2'b00};
                    r_wdata     <= w_wdata;
                    r_be        <= w_be;
                    r_off       <= ALUResultM[1:0];
                    r_size      <= Funct3M[1:0];
                    r_uns       <= Funct3M[2];
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= r_we ? DONE : RESP;
                    end else if (w_tmo) begin
                        r_req_valid <= 1'b0;
                        r_rdata     <= 32'h0;
                        r_buserr    <= 1'b1;
                        r_state     <= DONE;
                    end
                    r_cnt <= r_cnt + CW'(1);
                end
                RESP: begin
                    if (bus.mem_resp_valid) begin
                        r_rdata <= w_ext;
                        r_state <= DONE;
                    end else if (w_tmo) begin
                        r_rdata  <= 32'h0;
                        r_buserr <= 1'b1;
                        r_state  <= DONE;
                    end
                    r_cnt <= r_cnt + CW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gated with reset so a held access never stalls or flags while in reset.
    assign StallM    = reset & (((r_state == IDLE) & w_acc & w_aligned) |
                                (r_state == REQ) | (r_state == RESP));
    assign MisalignM = reset & (r_state == IDLE) & w_acc & ~w_aligned;
    assign ReadDataM = r_rdata;
    assign BusErrM   = r_buserr;

    assign bus.mem_req_valid = r_req_valid;
    assign bus.mem_req_we    = r_we;
    assign bus.mem_req_addr  = r_addr;
    assign bus.mem_req_wdata = r_wdata;
    assign bus.mem_req_be    = r_be;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a short timeout so the abort path is reachable.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM, BusErrM;
    int          n_chk = 0;
    int          n_err = 0;

    mem_lsu_if bus ();

    mem_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
        .BusErrM(BusErrM), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then stay 1 time unit past the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = 32'h0;
        cyc(); cyc();
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_buserr", {31'h0, BusErrM}, 32'h0);
        chk("rst_valid", {31'h0, bus.mem_req_valid}, 32'h0);
        chk("rst_be", {28'h0, bus.mem_req_be}, 32'h0);
        chk("rst_addr", bus.mem_req_addr, 32'h0);
        chk("rst_stall", {31'h0, StallM}, 32'h0);
        reset = 1'b1;
        cyc();

        // Store word, zero-wait
        drive(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF); bus.mem_req_ready = 1'b1; #1;
        chk("sw_idle_stall", {31'h0, StallM}, 32'h1);
        chk("sw_idle_valid", {31'h0, bus.mem_req_valid}, 32'h0);
        cyc();
        chk("sw_valid", {31'h0, bus.mem_req_valid}, 32'h1);
        chk("sw_be", {28'h0, bus.mem_req_be}, 32'hF);
        chk("sw_addr", bus.mem_req_addr, 32'h100);
        chk("sw_we", {31'h0, bus.mem_req_we}, 32'h1);
        chk("sw_wdata", bus.mem_req_wdata, 32'hDEADBEEF);
        chk("sw_req_stall", {31'h0, StallM}, 32'h1);
        cyc();
        chk("sw_done_stall", {31'h0, StallM}, 32'h0);
        chk("sw_done_valid", {31'h0, bus.mem_req_valid}, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc();

        // Store byte with both read and write set: must be a store
        drive(1'b1, 1'b1, 3'b000, 32'h102, 32'h12345678); cyc();
        chk("sb_we", {31'h0, bus.mem_req_we}, 32'h1);
        chk("sb_be", {28'h0, bus.mem_req_be}, 32'h4);
        chk("sb_wdata", bus.mem_req_wdata, 32'h78787878);
        cyc(); drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); cyc();

        // Store half, upper
        drive(1'b0, 1'b1, 3'b001, 32'h102, 32'h12345678); cyc();
        chk("sh_be", {28'h0, bus.mem_req_be}, 32'hC);
        chk("sh_wdata", bus.mem_req_wdata, 32'h56785678);
        cyc(); drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); cyc();

        // Load byte signed, response 2 cycles after accept
        drive(1'b1, 1'b0, 3'b000, 32'h103, 32'hFFFFFFFF); #1;
        chk("lb_stall1", {31'h0, StallM}, 32'h1);
        cyc();
        chk("lb_be", {28'h0, bus.mem_req_be}, 32'h8);
        chk("lb_we", {31'h0, bus.mem_req_we}, 32'h0);
        chk("lb_wdata", bus.mem_req_wdata, 32'h0);
        chk("lb_addr", bus.mem_req_addr, 32'h100);
        chk("lb_stall2", {31'h0, StallM}, 32'h1);
        cyc();
        chk("lb_stall3", {31'h0, StallM}, 32'h1);
        chk("lb_resp_valid", {31'h0, bus.mem_req_valid}, 32'h0);
        cyc();
        bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h80FF0000; #1;
        chk("lb_stall4", {31'h0, StallM}, 32'h1);
        cyc();
        bus.mem_resp_valid = 1'b0;
        chk("lb_data", ReadDataM, 32'hFFFFFF80);
        chk("lb_done_stall", {31'h0, StallM}, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); cyc();

        // Load half unsigned then signed
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, (k == 0) ? 3'b101 : 3'b001, 32'h102, 32'h0); cyc();
            chk("lh_be", {28'h0, bus.mem_req_be}, 32'hC);
            cyc();
            bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'hBEEF1234;
            cyc();
            bus.mem_resp_valid = 1'b0;
            chk(k == 0 ? "lhu_data" : "lh_data", ReadDataM, k == 0 ? 32'h0000BEEF : 32'hFFFFBEEF);
            drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); cyc();
        end
        chk("rdata_hold", ReadDataM, 32'hFFFFBEEF);

        // Misaligned / illegal accesses
        drive(1'b1, 1'b0, 3'b010, 32'h101, 32'h0); #1;
        chk("lw_mis", {31'h0, MisalignM}, 32'h1);
        chk("lw_mis_stall", {31'h0, StallM}, 32'h0);
        cyc();
        chk("lw_mis_valid", {31'h0, bus.mem_req_valid}, 32'h0);
        chk("lw_mis_rdata", ReadDataM, 32'hFFFFBEEF);
        drive(1'b0, 1'b1, 3'b001, 32'h203, 32'h55); #1;
        chk("sh_mis", {31'h0, MisalignM}, 32'h1);
        chk("sh_mis_stall", {31'h0, StallM}, 32'h0);
        cyc();
        chk("sh_mis_valid", {31'h0, bus.mem_req_valid}, 32'h0);
        drive(1'b1, 1'b0, 3'b011, 32'h100, 32'h0); #1;
        chk("ill_mis", {31'h0, MisalignM}, 32'h1);
        chk("ill_stall", {31'h0, StallM}, 32'h0);
        cyc();
        chk("ill_valid", {31'h0, bus.mem_req_valid}, 32'h0);
        drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0); #1;
        chk("lw_aligned_nomis", {31'h0, MisalignM}, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); cyc();

        // Backpressure: ready low for 5 REQ cycles
        bus.mem_req_ready = 1'b0;
        drive(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_valid", {31'h0, bus.mem_req_valid}, 32'h1);
            chk("bp_addr", bus.mem_req_addr, 32'h300);
            chk("bp_wdata", bus.mem_req_wdata, 32'hCAFEF00D);
            chk("bp_stall", {31'h0, StallM}, 32'h1);
        end
        bus.mem_req_ready = 1'b1;
        cyc();
        chk("bp_done_stall", {31'h0, StallM}, 32'h0);
        chk("bp_done_buserr", {31'h0, BusErrM}, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); cyc();

        // Timeout: ready never comes; 8 REQ cycles then DONE with bus error
        bus.mem_req_ready = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("to_stall", {31'h0, StallM}, 32'h1);
            chk("to_noerr", {31'h0, BusErrM}, 32'h0);
        end
        cyc();
        chk("to_buserr", {31'h0, BusErrM}, 32'h1);
        chk("to_rdata", ReadDataM, 32'h0);
        chk("to_done_stall", {31'h0, StallM}, 32'h0);
        chk("to_valid", {31'h0, bus.mem_req_valid}, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h77777777;
        cyc();
        chk("to_buserr_clr", {31'h0, BusErrM}, 32'h0);
        chk("to_late_rdata", ReadDataM, 32'h0);
        bus.mem_resp_valid = 1'b0; bus.mem_req_ready = 1'b1;

        // Load word pass-through, then reset in the middle of a load
        drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0); cyc(); cyc();
        bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h11223344;
        cyc();
        bus.mem_resp_valid = 1'b0;
        chk("lw_data", ReadDataM, 32'h11223344);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); cyc();
        drive(1'b1, 1'b0, 3'b010, 32'h504, 32'h0); cyc(); cyc();
        chk("mid_resp_stall", {31'h0, StallM}, 32'h1);
        reset = 1'b0; drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc();
        chk("mid_rst_valid", {31'h0, bus.mem_req_valid}, 32'h0);
        chk("mid_rst_stall", {31'h0, StallM}, 32'h0);
        chk("mid_rst_rdata", ReadDataM, 32'h0);
        reset = 1'b1;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h12345678;
        cyc(); cyc();
        chk("late_resp_rdata", ReadDataM, 32'h0);
        chk("late_resp_stall", {31'h0, StallM}, 32'h0);
        bus.mem_resp_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
